// File: rtl/chronos_mem_pkg.sv
// Shared constants for the memory stage: RV32I load/store width codes, FSM
// states and memory command encoding.
package chronos_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} mem_state_e;

  // Natural alignment check on the access size encoded in funct3[1:0].
  function automatic logic addr_aligned(input logic [2:0] funct3, input logic [1:0] offset);
    if (funct3[1:0] == F3_W[1:0]) return offset == 2'b00;
    if (funct3[1:0] == F3_H[1:0]) return ~offset[0];
    return 1'b1;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word and sign/zero extends it.
module load_align
  import chronos_mem_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];

    case (funct3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result_o = {24'b0, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result_o = {16'b0, half_sel};
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: one load/store at a time towards a simple
// enable/valid memory, stalling the pipeline until the response or a timeout.
module mem_stage_ctrl
  import chronos_mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic [XLEN-1:0] load_result,
  output logic            load_done,
  output logic            misaligned,
  output logic            timeout,
  output logic            mem_enable,
  output logic            mem_cmd,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_mask,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic            mem_valid
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  mem_state_e      state_q;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] load_result_q, mem_addr_q, mem_wdata_q;
  logic            load_done_q, misaligned_q, timeout_q, mem_enable_q, mem_cmd_q;
  logic [3:0]      mem_mask_q;

  logic            aligned, accept, expire;
  logic [3:0]      mask_c;
  logic [XLEN-1:0] wdata_c, extracted;

  load_align u_load_align (
    .data_i   (mem_load_data),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (extracted)
  );

  always_comb begin
    aligned = addr_aligned(req_funct3, req_addr[1:0]);
    accept  = (state_q == StIdle) && req_valid && aligned;
    stall   = accept || (state_q == StIssue) || (state_q == StWait);
    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    // A response in the expiring cycle wins over the timeout.
    expire  = (cnt_d == MaxWait);

    case (req_funct3[1:0])
      2'b00: begin
        mask_c  = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        mask_c  = 4'b0011 << {req_addr[1], 1'b0};
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        mask_c  = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      load_result_q <= '0;
      load_done_q   <= 1'b0;
      misaligned_q  <= 1'b0;
      timeout_q     <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_cmd_q     <= MEM_READ;
      mem_addr_q    <= '0;
      mem_mask_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      load_done_q  <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      mem_enable_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q      <= StIssue;
            mem_enable_q <= 1'b1;
            mem_cmd_q    <= req_write ? MEM_WRITE : MEM_READ;
            mem_addr_q   <= {req_addr[XLEN-1:2], 2'b00};
            mem_mask_q   <= mask_c;
            mem_wdata_q  <= wdata_c;
            f3_q         <= req_funct3;
            off_q        <= req_addr[1:0];
          end else if (req_valid) begin
            misaligned_q <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWait;
          cnt_q   <= '0;
        end
        StWait: begin
          cnt_q <= cnt_d;
          if (mem_valid || expire) begin
            state_q   <= StDone;
            timeout_q <= ~mem_valid;
            if (mem_cmd_q == MEM_READ) begin
              load_done_q   <= 1'b1;
              load_result_q <= mem_valid ? extracted : '0;
            end
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

  assign load_result    = load_result_q;
  assign load_done      = load_done_q;
  assign misaligned     = misaligned_q;
  assign timeout        = timeout_q;
  assign mem_enable     = mem_enable_q;
  assign mem_cmd        = mem_cmd_q;
  assign mem_addr       = mem_addr_q;
  assign mem_mask       = mem_mask_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_stage_ctrl;

  localparam int TbMaxWait = 4;

  logic        clk, rst;
  logic        req_valid, req_write, mem_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_load_data;
  logic        stall, load_done, misaligned, timeout, mem_enable, mem_cmd;
  logic [31:0] load_result, mem_addr, mem_write_data;
  logic [3:0]  mem_mask;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_result = 32'd0;
  logic [2:0]  f3_list [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  mem_stage_ctrl #(.MAX_WAIT(TbMaxWait), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .load_result    (load_result),
    .load_done      (load_done),
    .misaligned     (misaligned),
    .timeout        (timeout),
    .mem_enable     (mem_enable),
    .mem_cmd        (mem_cmd),
    .mem_addr       (mem_addr),
    .mem_mask       (mem_mask),
    .mem_write_data (mem_write_data),
    .mem_load_data  (mem_load_data),
    .mem_valid      (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model: access size in bytes is 2**funct3[1:0].
  function automatic int nbytes_m(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit aligned_m(input logic [2:0] f3, input logic [31:0] a);
    return (a % 32'(nbytes_m(f3))) == 32'd0;
  endfunction

  function automatic logic [3:0] mask_m(input logic [2:0] f3, input logic [1:0] off);
    return 4'(((1 << nbytes_m(f3)) - 1) << off);
  endfunction

  function automatic logic [31:0] wdata_m(input logic [2:0] f3, input logic [31:0] d);
    longint rep, span;
    int nb;
    nb = nbytes_m(f3);
    span = longint'(1) << (8 * nb);
    rep = 0;
    for (int i = 0; i < 4 / nb; i++) rep += longint'(1) << (8 * nb * i);
    return 32'((longint'(d) % span) * rep);
  endfunction

  function automatic logic [31:0] extract_m(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
    longint span, v;
    span = longint'(1) << (8 * nbytes_m(f3));
    v = (longint'(w) >> (8 * int'(off))) % span;
    if (!f3[2] && nbytes_m(f3) < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  task automatic drive_busy(input bit noise);
    if (noise) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_write  = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    mem_valid = 1'($urandom_range(0, 1));
    mem_load_data = $urandom;
    #1;
    check_eq("idle_stall", 32'(stall), 32'd0);
    check_eq("idle_done", 32'(load_done), 32'd0);
    check_eq("idle_timeout", 32'(timeout), 32'd0);
    check_eq("idle_men", 32'(mem_enable), 32'd0);
    check_eq("idle_result", load_result, exp_result);
    @(negedge clk);
  endtask

  // One request issued in an idle cycle; lat = WAIT cycles before mem_valid,
  // lat >= TbMaxWait means the memory never answers.
  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int lat,
                         input bit noise);
    bit ok, resp;
    int waits, stalls;
    ok = aligned_m(f3, addr);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_load_data = $urandom;
    #1;
    check_eq("req_stall", 32'(stall), 32'(ok));
    check_eq("req_done_low", 32'(load_done), 32'd0);
    check_eq("req_mis_low", 32'(misaligned), 32'd0);
    check_eq("req_men", 32'(mem_enable), 32'd0);
    check_eq("req_result", load_result, exp_result);
    stalls = int'(stall);
    @(negedge clk);
    if (!ok) begin
      req_valid = 1'b0;
      mem_valid = 1'b0;
      #1;
      check_eq("mis_pulse", 32'(misaligned), 32'd1);
      check_eq("mis_stall", 32'(stall), 32'd0);
      check_eq("mis_men", 32'(mem_enable), 32'd0);
      check_eq("mis_done", 32'(load_done), 32'd0);
      @(negedge clk);
      return;
    end
    drive_busy(noise);
    mem_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    check_eq("iss_men", 32'(mem_enable), 32'd1);
    check_eq("iss_cmd", 32'(mem_cmd), 32'(wr));
    check_eq("iss_addr", mem_addr, addr & 32'hFFFF_FFFC);
    check_eq("iss_mask", 32'(mem_mask), 32'(mask_m(f3, addr[1:0])));
    if (wr) check_eq("iss_wdata", mem_write_data, wdata_m(f3, wdata));
    stalls += int'(stall);
    @(negedge clk);
    resp  = lat < TbMaxWait;
    waits = resp ? lat + 1 : TbMaxWait;
    for (int k = 0; k < waits; k++) begin
      drive_busy(noise);
      mem_valid = (k == lat);
      mem_load_data = (k == lat) ? rdata : $urandom;
      #1;
      check_eq("wait_men", 32'(mem_enable), 32'd0);
      check_eq("wait_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check_eq("wait_mask", 32'(mem_mask), 32'(mask_m(f3, addr[1:0])));
      check_eq("wait_done", 32'(load_done), 32'd0);
      stalls += int'(stall);
      @(negedge clk);
    end
    drive_busy(noise);
    mem_valid = 1'($urandom_range(0, 1));
    mem_load_data = $urandom;
    if (!wr) exp_result = resp ? extract_m(rdata, f3, addr[1:0]) : 32'd0;
    #1;
    check_eq("done_stall", 32'(stall), 32'd0);
    check_eq("done_pulse", 32'(load_done), 32'(!wr));
    check_eq("done_timeout", 32'(timeout), 32'(!resp));
    check_eq("done_result", load_result, exp_result);
    check_eq("done_men", 32'(mem_enable), 32'd0);
    stalls += int'(stall);
    check_eq("stall_cycles", 32'(stalls), 32'(waits + 2));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_valid = 1'b0; mem_load_data = 32'd0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_result", load_result, 32'd0);
    check_eq("rst_flags", {28'd0, load_done, misaligned, timeout, mem_enable}, 32'd0);
    check_eq("rst_cmd_mask", {27'd0, mem_cmd, mem_mask}, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_wdata", mem_write_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80AA_BBCC, 0, 1'b0);  // LB
    run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'd0, 0, 1'b0);  // SH
    run_txn(1'b0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 0, 1'b0);          // LW misaligned
    idle_cycle();
    run_txn(1'b0, 3'b101, 32'h0000_0000, 32'd0, 32'hDEAD_BEEF, TbMaxWait, 1'b0);  // timeout
    idle_cycle();
    run_txn(1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'h8001_7FFE, TbMaxWait - 1, 1'b0);
    run_txn(1'b0, 3'b010, 32'h0000_0010, 32'd0, 32'h1122_3344, 1, 1'b0);
    run_txn(1'b0, 3'b100, 32'h0000_0011, 32'd0, 32'h1122_3344, 0, 1'b0);

    // Asynchronous reset in the middle of WAIT, then a stale response.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    mem_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("prerst_stall", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    exp_result = 32'd0;
    check_eq("arst_stall", 32'(stall), 32'd0);
    check_eq("arst_result", load_result, 32'd0);
    check_eq("arst_addr", mem_addr, 32'd0);
    check_eq("arst_mask", 32'(mem_mask), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_valid = 1'b1;
    mem_load_data = 32'hCAFE_F00D;
    #1;
    check_eq("stale_stall", 32'(stall), 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    check_eq("stale_done", 32'(load_done), 32'd0);
    check_eq("stale_timeout", 32'(timeout), 32'd0);
    check_eq("stale_result", load_result, 32'd0);
    @(negedge clk);

    for (int t = 0; t < 150; t++) begin
      logic       wr;
      logic [2:0] f3;
      wr = 1'($urandom_range(0, 1));
      f3 = wr ? f3_list[$urandom_range(0, 2)] : f3_list[$urandom_range(0, 4)];
      run_txn(wr, f3, $urandom & 32'h0000_FFFF, $urandom, $urandom,
              int'($urandom_range(0, TbMaxWait)), 1'b1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
